jackpot_ctrl: RTL and testbench

Game sequencer for the 4-LED jackpot board. It generates the spin step rate from the board clock and runs the one-hot LED rotation. It synchronises and edge-detects the player's switches and button, detects a hit, and runs the win blink. On each hit it raises the difficulty level, which makes the spin faster, and it keeps a saturating score. It sits between the board pins (SWITCHES, BTN) and the LEDs, and replaces free-running divider-bit clocking with a single-clock, tick-enabled design.

---
 rtl/jackpot_pkg.sv | 18 +
 rtl/jackpot_tick_gen.sv | 37 +++
 rtl/jackpot_ctrl.sv | 143 ++++++++++++++
 tb/tb_jackpot_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/jackpot_pkg.sv
// Shared state encoding, LED constants and helpers for the jackpot sequencer.
package jackpot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SPIN = 2'd1,
    ST_WIN  = 2'd2
  } state_e;

  localparam logic [3:0] LED_HOME  = 4'b0001;
  localparam logic [3:0] LED_ALL   = 4'b1111;
  localparam logic [7:0] SCORE_MAX = 8'd255;

  function automatic logic [3:0] rotate_led(input logic [3:0] leds);
    return {leds[2:0], leds[3]};
  endfunction

endpackage

// File: rtl/jackpot_tick_gen.sv
// Step-tick generator: one-cycle pulse every (TICK_DIV >> LEVEL) cycles while enabled.
module jackpot_tick_gen
  import jackpot_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       enable,
  input  logic       clear,
  input  logic [1:0] LEVEL,
  output logic       tick
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic [31:0] period_m1;

  always_comb begin
    period_m1 = (32'(TICK_DIV) >> LEVEL) - 32'd1;
    tick      = enable && (cnt_q == period_m1);
    cnt_d     = cnt_q + 32'd1;
    // A pending clear wins over counting so the new state/level starts a full period.
    if (clear || !enable || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/jackpot_ctrl.sv
// Jackpot game sequencer: input synchronisers, spin/win FSM, level and saturating score.
module jackpot_ctrl
  import jackpot_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 25000000,
  parameter int unsigned WIN_TICKS = 8,
  parameter int unsigned MAX_LEVEL = 3
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       START,
  input  logic [3:0] SWITCHES,
  output logic [3:0] LEDS,
  output logic       WIN,
  output logic [1:0] LEVEL,
  output logic [7:0] SCORE
);

  localparam int unsigned BLINK_W = $clog2(WIN_TICKS + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(WIN_TICKS - 1);
  localparam logic [1:0] LEVEL_MAX = 2'(MAX_LEVEL);

  logic [3:0] sw_s1_q, sw_s2_q, sw_s3_q;
  logic       st_s1_q, st_s2_q, st_s3_q;

  state_e             state_q, state_d;
  logic [3:0]         leds_q, leds_d;
  logic               win_q, win_d;
  logic [1:0]         level_q, level_d;
  logic [7:0]         score_q, score_d;
  logic [BLINK_W-1:0] blink_q, blink_d;

  logic sw_chg, start_rise, hit, miss;
  logic tick, tick_en, tick_clear;

  assign tick_en    = (state_q == ST_SPIN) || (state_q == ST_WIN);
  assign tick_clear = (state_d != state_q) || (level_d != level_q);

  jackpot_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .enable(tick_en),
    .clear (tick_clear),
    .LEVEL (level_q),
    .tick  (tick)
  );

  always_comb begin
    sw_chg     = (sw_s2_q != sw_s3_q);
    start_rise = st_s2_q & ~st_s3_q;
    hit        = sw_chg && (sw_s2_q == leds_q);
    miss       = sw_chg && (sw_s2_q != leds_q) && (sw_s2_q != 4'b0000);

    state_d = state_q;
    leds_d  = leds_q;
    level_d = level_q;
    score_d = score_q;
    blink_d = blink_q;

    case (state_q)
      ST_IDLE: begin
        leds_d = LED_HOME;
        if (start_rise) begin
          state_d = ST_SPIN;
        end
      end
      ST_SPIN: begin
        // Hit beats miss beats tick: the captured spinner position never advances on a hit.
        if (hit) begin
          state_d = ST_WIN;
          leds_d  = LED_ALL;
          blink_d = '0;
          if (score_q != SCORE_MAX) begin
            score_d = score_q + 8'd1;
          end
          if (level_q < LEVEL_MAX) begin
            level_d = level_q + 2'd1;
          end
        end else if (miss) begin
          level_d = 2'd0;
        end else if (tick) begin
          leds_d = rotate_led(leds_q);
        end
      end
      ST_WIN: begin
        if (tick) begin
          if (blink_q == BLINK_LAST) begin
            state_d = ST_SPIN;
            leds_d  = LED_HOME;
            blink_d = '0;
          end else begin
            leds_d  = ~leds_q;
            blink_d = blink_q + BLINK_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        leds_d  = LED_HOME;
      end
    endcase

    win_d = (state_d == ST_WIN);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      sw_s3_q <= '0;
      st_s1_q <= 1'b0;
      st_s2_q <= 1'b0;
      st_s3_q <= 1'b0;
      state_q <= ST_IDLE;
      leds_q  <= LED_HOME;
      win_q   <= 1'b0;
      level_q <= 2'd0;
      score_q <= 8'd0;
      blink_q <= '0;
    end else begin
      sw_s1_q <= SWITCHES;
      sw_s2_q <= sw_s1_q;
      sw_s3_q <= sw_s2_q;
      st_s1_q <= START;
      st_s2_q <= st_s1_q;
      st_s3_q <= st_s2_q;
      state_q <= state_d;
      leds_q  <= leds_d;
      win_q   <= win_d;
      level_q <= level_d;
      score_q <= score_d;
      blink_q <= blink_d;
    end
  end

  assign LEDS  = leds_q;
  assign WIN   = win_q;
  assign LEVEL = level_q;
  assign SCORE = score_q;

endmodule

// File: tb/tb_jackpot_ctrl.sv
// Directed bench for jackpot_ctrl with TICK_DIV=16, WIN_TICKS=4, MAX_LEVEL=3.
module tb_jackpot_ctrl;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [3:0] SWITCHES = 4'b0000;
  logic [3:0] LEDS;
  logic       WIN;
  logic [1:0] LEVEL;
  logic [7:0] SCORE;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jackpot_ctrl #(
    .TICK_DIV (16),
    .WIN_TICKS(4),
    .MAX_LEVEL(3)
  ) dut (
    .CLOCK   (clk),
    .RESET   (RESET),
    .START   (START),
    .SWITCHES(SWITCHES),
    .LEDS    (LEDS),
    .WIN     (WIN),
    .LEVEL   (LEVEL),
    .SCORE   (SCORE)
  );

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    clk_n(2);
    RESET = 1'b0;
  endtask

  task automatic start_game();
    START = 1'b1;
    clk_n(3);
    START = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    START = 1'b0;
    SWITCHES = 4'b0000;
    clk_n(2);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL reset_leds: got %b expected 0001", LEDS); end
    checks++; if (WIN !== 1'b0) begin errors++; $display("FAIL reset_win: got %b expected 0", WIN); end
    checks++; if (LEVEL !== 2'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", LEVEL); end
    checks++; if (SCORE !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", SCORE); end
    RESET = 1'b0;
    clk_n(100);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL idle_leds: got %b expected 0001", LEDS); end
    checks++; if (WIN !== 1'b0) begin errors++; $display("FAIL idle_win: got %b expected 0", WIN); end
    $display("test_reset: done, errors so far %0d", errors);
  endtask

  task automatic test_spin();
    start_game();
    clk_n(15);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL spin_pre_tick: got %b expected 0001", LEDS); end
    clk_n(1);
    checks++; if (LEDS !== 4'b0010) begin errors++; $display("FAIL spin_step1: got %b expected 0010", LEDS); end
    clk_n(16);
    checks++; if (LEDS !== 4'b0100) begin errors++; $display("FAIL spin_step2: got %b expected 0100", LEDS); end
    clk_n(16);
    checks++; if (LEDS !== 4'b1000) begin errors++; $display("FAIL spin_step3: got %b expected 1000", LEDS); end
    clk_n(16);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL spin_wrap: got %b expected 0001", LEDS); end
    $display("test_spin: done, errors so far %0d", errors);
  endtask

  task automatic test_hit();
    clk_n(32);
    checks++; if (LEDS !== 4'b0100) begin errors++; $display("FAIL hit_pos: got %b expected 0100", LEDS); end
    SWITCHES = 4'b0100;
    clk_n(2);
    checks++; if (WIN !== 1'b0) begin errors++; $display("FAIL hit_early: got %b expected 0", WIN); end
    clk_n(1);
    checks++; if (WIN !== 1'b1) begin errors++; $display("FAIL hit_win: got %b expected 1", WIN); end
    checks++; if (SCORE !== 8'd1) begin errors++; $display("FAIL hit_score: got %0d expected 1", SCORE); end
    checks++; if (LEVEL !== 2'd1) begin errors++; $display("FAIL hit_level: got %0d expected 1", LEVEL); end
    checks++; if (LEDS !== 4'b1111) begin errors++; $display("FAIL blink0: got %b expected 1111", LEDS); end
    clk_n(7);
    checks++; if (LEDS !== 4'b1111) begin errors++; $display("FAIL blink0_hold: got %b expected 1111", LEDS); end
    clk_n(1);
    checks++; if (LEDS !== 4'b0000) begin errors++; $display("FAIL blink1: got %b expected 0000", LEDS); end
    clk_n(8);
    checks++; if (LEDS !== 4'b1111) begin errors++; $display("FAIL blink2: got %b expected 1111", LEDS); end
    clk_n(8);
    checks++; if (LEDS !== 4'b0000) begin errors++; $display("FAIL blink3: got %b expected 0000", LEDS); end
    clk_n(8);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL win_exit_leds: got %b expected 0001", LEDS); end
    checks++; if (WIN !== 1'b0) begin errors++; $display("FAIL win_exit_win: got %b expected 0", WIN); end
    $display("test_hit: done, errors so far %0d", errors);
  endtask

  task automatic test_static();
    int win_seen;
    SWITCHES = 4'b0010;
    do_reset();
    clk_n(5);
    start_game();
    win_seen = 0;
    for (int i = 0; i < 640; i++) begin
      clk_n(1);
      if (WIN === 1'b1) win_seen++;
    end
    checks++; if (win_seen !== 0) begin errors++; $display("FAIL static_no_win: got %0d win cycles expected 0", win_seen); end
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL static_rot: got %b expected 0001", LEDS); end
    clk_n(16);
    SWITCHES = 4'b1000;
    clk_n(3);
    checks++; if (LEVEL !== 2'd0) begin errors++; $display("FAIL static_miss_level: got %0d expected 0", LEVEL); end
    checks++; if (WIN !== 1'b0) begin errors++; $display("FAIL static_miss_win: got %b expected 0", WIN); end
    checks++; if (LEDS !== 4'b0010) begin errors++; $display("FAIL static_miss_leds: got %b expected 0010", LEDS); end
    clk_n(13);
    checks++; if (LEDS !== 4'b0100) begin errors++; $display("FAIL static_keep_spin: got %b expected 0100", LEDS); end
    $display("test_static: done, errors so far %0d", errors);
  endtask

  task automatic test_levels();
    SWITCHES = 4'b0000;
    do_reset();
    start_game();
    // Hit 1 at level 0
    SWITCHES = 4'b0001;
    clk_n(3);
    checks++; if (WIN !== 1'b1 || LEVEL !== 2'd1) begin errors++; $display("FAIL hit1: got win=%b level=%0d expected win=1 level=1", WIN, LEVEL); end
    SWITCHES = 4'b0000;
    clk_n(32);
    checks++; if (WIN !== 1'b0 || LEDS !== 4'b0001) begin errors++; $display("FAIL hit1_exit: got win=%b leds=%b expected win=0 leds=0001", WIN, LEDS); end
    // Hit 2 at level 1
    SWITCHES = 4'b0001;
    clk_n(3);
    checks++; if (WIN !== 1'b1 || LEVEL !== 2'd2) begin errors++; $display("FAIL hit2: got win=%b level=%0d expected win=1 level=2", WIN, LEVEL); end
    SWITCHES = 4'b0000;
    clk_n(16);
    checks++; if (WIN !== 1'b0 || LEDS !== 4'b0001) begin errors++; $display("FAIL hit2_exit: got win=%b leds=%b expected win=0 leds=0001", WIN, LEDS); end
    // Hit 3 at level 2
    SWITCHES = 4'b0001;
    clk_n(3);
    checks++; if (WIN !== 1'b1 || LEVEL !== 2'd3) begin errors++; $display("FAIL hit3: got win=%b level=%0d expected win=1 level=3", WIN, LEVEL); end
    SWITCHES = 4'b0000;
    clk_n(8);
    checks++; if (WIN !== 1'b0 || LEDS !== 4'b0001) begin errors++; $display("FAIL hit3_exit: got win=%b leds=%b expected win=0 leds=0001", WIN, LEDS); end
    // Level 3 step period is two cycles
    clk_n(1);
    checks++; if (LEDS !== 4'b0001) begin errors++; $display("FAIL l3_hold: got %b expected 0001", LEDS); end
    clk_n(1);
    checks++; if (LEDS !== 4'b0010) begin errors++; $display("FAIL l3_step1: got %b expected 0010", LEDS); end
    clk_n(2);
    checks++; if (LEDS !== 4'b0100) begin errors++; $display("FAIL l3_step2: got %b expected 0100", LEDS); end
    // Hit 4 lands on a tick cycle with LEDS=1000
    clk_n(1);
    SWITCHES = 4'b1000;
    clk_n(2);
    checks++; if (WIN !== 1'b0) begin errors++; $display("FAIL hit4_early: got %b expected 0", WIN); end
    clk_n(1);
    checks++; if (WIN !== 1'b1 || LEVEL !== 2'd3 || SCORE !== 8'd4) begin errors++; $display("FAIL hit4: got win=%b level=%0d score=%0d expected win=1 level=3 score=4", WIN, LEVEL, SCORE); end
    SWITCHES = 4'b0000;
    clk_n(8);
    checks++; if (WIN !== 1'b0 || LEDS !== 4'b0001) begin errors++; $display("FAIL hit4_exit: got win=%b leds=%b expected win=0 leds=0001", WIN, LEDS); end
    $display("test_levels: done, errors so far %0d", errors);
  endtask

  task automatic test_score_sat();
    int wins;
    wins = 0;
    for (int i = 0; i < 251; i++) begin
      SWITCHES = 4'b0010;
      clk_n(3);
      if (WIN === 1'b1) wins++;
      SWITCHES = 4'b0000;
      clk_n(8);
    end
    checks++; if (wins !== 251) begin errors++; $display("FAIL sat_hits: got %0d expected 251", wins); end
    checks++; if (SCORE !== 8'd255) begin errors++; $display("FAIL sat_reach: got %0d expected 255", SCORE); end
    SWITCHES = 4'b0010;
    clk_n(3);
    checks++; if (WIN !== 1'b1 || SCORE !== 8'd255) begin errors++; $display("FAIL sat_hold: got win=%b score=%0d expected win=1 score=255", WIN, SCORE); end
    SWITCHES = 4'b0000;
    clk_n(8);
    // Miss at level 3 drops back to level 0
    SWITCHES = 4'b0100;
    clk_n(3);
    checks++; if (LEVEL !== 2'd0 || WIN !== 1'b0 || LEDS !== 4'b0010) begin errors++; $display("FAIL miss_l3: got level=%0d win=%b leds=%b expected level=0 win=0 leds=0010", LEVEL, WIN, LEDS); end
    SWITCHES = 4'b0010;
    clk_n(3);
    checks++; if (WIN !== 1'b1 || SCORE !== 8'd255 || LEVEL !== 2'd1) begin errors++; $display("FAIL sat_hold2: got win=%b score=%0d level=%0d expected win=1 score=255 level=1", WIN, SCORE, LEVEL); end
    clk_n(8);
    checks++; if (LEDS !== 4'b0000) begin errors++; $display("FAIL mid_blink: got %b expected 0000", LEDS); end
    RESET = 1'b1;
    clk_n(1);
    checks++; if (LEDS !== 4'b0001 || WIN !== 1'b0 || SCORE !== 8'd0 || LEVEL !== 2'd0) begin errors++; $display("FAIL reset_in_win: got leds=%b win=%b score=%0d level=%0d expected 0001 0 0 0", LEDS, WIN, SCORE, LEVEL); end
    RESET = 1'b0;
    clk_n(40);
    checks++; if (LEDS !== 4'b0001 || WIN !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got leds=%b win=%b expected 0001 0", LEDS, WIN); end
    $display("test_score_sat: done, errors so far %0d", errors);
  endtask

  initial begin
    test_reset();
    test_spin();
    test_hit();
    test_static();
    test_levels();
    test_score_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
